// File: rtl/channel_accum_pkg.sv
// Shared definitions for channel_accum: data width, accumulator guard bits, FSM encodings.
// Widths come from the Data_len / Acc_guard macros when the build provides them.
`ifndef Data_len
`define Data_len 16
`endif
`ifndef Acc_guard
`define Acc_guard 3
`endif

package channel_accum_pkg;

  localparam int DATA_LEN  = `Data_len;
  localparam int ACC_GUARD = `Acc_guard;

  // OUT sits outside the 2-bit range, so the state field is 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACC  = 3'd1,
    ST_BIAS = 3'd2,
    ST_SAT  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/channel_accum_acc_saturate.sv
// Combinational clamp of an ACC_W-bit signed accumulator to DATA_LEN bits.
// CHANNEL_ACCUM_RELU_EN: negative accumulators clamp to zero instead of passing through.
module channel_accum_acc_saturate
  import channel_accum_pkg::*;
#(
  parameter int ACC_W = DATA_LEN + ACC_GUARD
) (
  input  logic signed [ACC_W-1:0]    acc,
  output logic signed [DATA_LEN-1:0] q
);

  logic fits;

  // value fits when every bit above the result's sign bit equals the sign
  assign fits = (acc[ACC_W-1:DATA_LEN-1] == {(ACC_W-DATA_LEN+1){acc[ACC_W-1]}});

  always_comb begin
    q = acc[DATA_LEN-1:0];
    if (!fits) begin
      q = acc[ACC_W-1] ? {1'b1, {(DATA_LEN-1){1'b0}}} : {1'b0, {(DATA_LEN-1){1'b1}}};
    end
`ifdef CHANNEL_ACCUM_RELU_EN
    if (acc[ACC_W-1]) begin
      q = '0;
    end
`endif
  end

endmodule

// File: rtl/channel_accum.sv
// Per-channel accumulator: sums NUM_PHASE in-order partials, adds BIAS, saturates, hands off via valid/ready.
// Optional CHANNEL_ACCUM_RELU_EN macro selects ReLU clamping inside the saturation stage.
module channel_accum
  import channel_accum_pkg::*;
#(
  parameter int                         NUM_PHASE = 6,
  parameter logic signed [DATA_LEN-1:0] BIAS      = '0,
  parameter int                         GUARD     = ACC_GUARD
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [2:0]                 in_phase,
  input  logic signed [DATA_LEN-1:0] in_data,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [DATA_LEN-1:0] q,
  output logic                       busy,
  output logic                       err
);

  localparam int ACC_W = DATA_LEN + GUARD;

  state_t                  state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg;
  logic [3:0]              cnt_reg;
  logic                    prev_valid_reg;
  logic                    rise, phase_ok, last_sample;
  logic signed [ACC_W-1:0] data_ext, bias_ext;
  logic signed [DATA_LEN-1:0] sat_q;

  assign rise        = in_valid & ~prev_valid_reg;
  assign phase_ok    = ({1'b0, in_phase} == cnt_reg);
  assign last_sample = rise && phase_ok && (cnt_reg == 4'(NUM_PHASE - 1));
  assign data_ext    = {{GUARD{in_data[DATA_LEN-1]}}, in_data};
  assign bias_ext    = {{GUARD{BIAS[DATA_LEN-1]}}, BIAS};

  channel_accum_acc_saturate #(.ACC_W(ACC_W)) u_sat (
    .acc (acc_reg),
    .q   (sat_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_ACC;
    end else begin
      case (state_reg)
        ST_ACC:  if (last_sample) state_next = ST_BIAS;
        ST_BIAS: state_next = ST_SAT;
        ST_SAT:  state_next = ST_OUT;
        ST_OUT:  if (out_ready) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_reg != ST_IDLE);
  end

  // start has priority over any sample edge arriving in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      prev_valid_reg <= 1'b0;
      out_valid      <= 1'b0;
      q              <= '0;
      err            <= 1'b0;
    end else begin
      prev_valid_reg <= in_valid;
      if (start) begin
        acc_reg   <= '0;
        cnt_reg   <= '0;
        err       <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        case (state_reg)
          ST_ACC: begin
            if (rise) begin
              if (phase_ok) begin
                acc_reg <= acc_reg + data_ext;
                cnt_reg <= cnt_reg + 4'd1;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_BIAS: begin
            acc_reg <= acc_reg + bias_ext;
            if (rise) err <= 1'b1;
          end
          ST_SAT: begin
            q         <= sat_q;
            out_valid <= 1'b1;
            if (rise) err <= 1'b1;
          end
          ST_OUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              acc_reg   <= '0;
              cnt_reg   <= '0;
            end
            if (rise) err <= 1'b1;
          end
          default: begin
            if (rise) err <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_channel_accum.sv
// Scoreboard bench for channel_accum (DATA_LEN=16, NUM_PHASE=6, BIAS=10).
module tb_channel_accum;
  import channel_accum_pkg::*;

  localparam int DL = DATA_LEN;

  typedef struct {
    logic signed [DL-1:0] q;
    logic                 err;
  } exp_t;

  logic                 clk, rst_n, start, in_valid, out_ready;
  logic [2:0]           in_phase;
  logic signed [DL-1:0] in_data;
  logic                 out_valid, busy, err;
  logic signed [DL-1:0] q;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  channel_accum #(.NUM_PHASE(6), .BIAS(16'sd10), .GUARD(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_phase  (in_phase),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .q         (q),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got q=%0d, required no output", q);
        end else begin
          e = sb.pop_front();
          check("sb_q", int'(q), int'(e.q));
          check("sb_err", int'(err), int'(e.err));
        end
      end
    end
  endtask

  task automatic push(input int eq, input bit ee);
    exp_t e;
    e.q   = DL'(eq);
    e.err = ee;
    sb.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // in_valid held 3 cycles then low 1; optional check that out_valid rises on the 3rd edge
  task automatic pulse(input int ph, input int d, input bit lat_chk, input string tag);
    in_phase = 3'(ph);
    in_data  = DL'(d);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (lat_chk) check({tag, "_latency"}, int'(out_valid), (k == 2) ? 1 : 0);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic frame_const(input int d, input int eq, input bit ee, input bit with_start,
                             input string tag);
    push(eq, ee);
    if (with_start) do_start();
    for (int i = 0; i < 6; i++) pulse(i, d, i == 5, tag);
    wait_idle(tag);
  endtask

  initial begin
    int neg_q;
    int seq_ph[7];
    int seq_d[7];
    seq_ph = '{0, 1, 3, 2, 3, 4, 5};
    seq_d  = '{1, 2, 999, 4, 8, 16, 32};
`ifdef CHANNEL_ACCUM_RELU_EN
    neg_q = 0;
`else
    neg_q = -32768;
`endif
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_phase = '0; in_data = '0; out_ready = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_q", int'(q), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    tick();

    frame_const(100, 610, 1'b0, 1'b1, "basic");
    frame_const(30000, 32767, 1'b0, 1'b1, "sat_pos");
    frame_const(-30000, neg_q, 1'b0, 1'b1, "sat_neg");

    // out-of-order phase is dropped, later in-order samples still accepted
    push(73, 1'b1);
    do_start();
    for (int i = 0; i < 7; i++) begin
      pulse(seq_ph[i], seq_d[i], i == 6, "phase_seq");
      if (i == 2) check("phase_seq_err", int'(err), 1);
    end
    wait_idle("phase_seq");

    // backpressure with an overrun edge while the result is held
    push(52, 1'b1);
    out_ready = 1'b0;
    do_start();
    for (int i = 0; i < 6; i++) pulse(i, 7, 1'b0, "bp");
    for (int k = 0; k < 5; k++) begin
      check("bp_valid_held", int'(out_valid), 1);
      check("bp_q_stable", int'(q), 52);
      if (k == 1) in_valid = 1'b1;
      if (k == 2) in_valid = 1'b0;
      tick();
    end
    check("bp_err", int'(err), 1);
    check("bp_valid_6th", int'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    check("bp_valid_drop", int'(out_valid), 0);
    check("bp_busy_idle", int'(busy), 0);

    // asynchronous reset mid-frame
    do_start();
    pulse(0, 5, 1'b0, "rst");
    pulse(1, 5, 1'b0, "rst");
    pulse(3, 5, 1'b0, "rst");
    check("rst_mid_err_before", int'(err), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", int'(out_valid), 0);
    check("rst_mid_q", int'(q), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_err", int'(err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    frame_const(5, 40, 1'b0, 1'b1, "after_rst");

    // start coinciding with a sample edge: start wins, sample not counted
    do_start();
    pulse(0, 50, 1'b0, "coll");
    pulse(1, 50, 1'b0, "coll");
    pulse(5, 50, 1'b0, "coll");
    check("coll_err_before", int'(err), 1);
    start    = 1'b1;
    in_valid = 1'b1;
    in_phase = 3'd0;
    in_data  = DL'(50);
    tick();
    start = 1'b0;
    check("coll_err", int'(err), 0);
    check("coll_busy", int'(busy), 1);
    in_valid = 1'b0;
    tick();
    frame_const(1, 16, 1'b0, 1'b0, "coll");

    repeat (5) tick();
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
